seg_rx: RTL

- Receive-side decoder for the serial 7-segment display link: two daisy-chained 8-bit shift registers feeding 8 digits.
- Samples the link's ds, shift-clock and store-clock wires in the system clock domain and rebuilds the 16-bit store-register content. Each word holds a one-hot digit select and an active-low segment pattern.
- Maps each pattern back to a hex nibble and keeps the 8-digit value that is being displayed.
- Used as a loop-back checker on the board and as the bench monitor for the display driver.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_pat_decode.sv | 24 ++
 rtl/seg_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment link receiver.
// SEG_TABLE[v] is the 8-bit low byte of a link word for hex value v.
// Its bits [7:1] are segments a..g, active-low. Bit 0 is the decimal point,
// also active-low, and is shown here as 1, meaning off.
package seg_pkg;

  typedef logic [3:0]  u4;
  typedef logic [15:0] u16;

  localparam int unsigned WORD_BITS = 16;

  // Index 0 is the right-most element of the concatenation.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

endpackage

// File: rtl/seg_pat_decode.sv
// Combinational reverse lookup of a 7-bit active-low segment pattern.
//   pat_i    : segments a..g, taken from word bits [7:1]
//   hit_o    : pattern found in the table
//   nibble_o : hex value of the pattern; 0 when there is no hit
module seg_pat_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       hit_o,
  output u4          nibble_o
);

  always_comb begin
    hit_o    = 1'b0;
    nibble_o = '0;
    for (int v = 0; v < 16; v++) begin
      if (SEG_TABLE[v][7:1] == pat_i) begin
        hit_o    = 1'b1;
        nibble_o = u4'(v);
      end
    end
  end

endmodule

// File: rtl/seg_rx.sv
// Receive-side decoder for the serial 7-segment display link.
// It rebuilds the 16-bit store-register word, decodes the one-hot digit
// select and the segment pattern, and tracks complete 8-digit frames.
//   clk_i, rst_i            : system clock; asynchronous active-high reset
//   sh_clk_i, ds_i, st_clk_i: raw link wires for shift clock, data and store clock
//   digits_o, dp_o          : live digit nibbles and decimal points
//   frame_o, frame_valid_o  : frame snapshot and its one-cycle strobe
//   latch_valid_o           : one-cycle strobe for each accepted word
//   pat_err_o, sel_err_o,
//   len_err_o               : one-cycle error strobes
//   frame_cnt_o             : count of completed frames; wraps
module seg_rx
  import seg_pkg::*;
#(
  parameter int unsigned SYNC    = 2,
  parameter int unsigned GUARD   = 2,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sh_clk_i,
  input  logic        ds_i,
  input  logic        st_clk_i,
  output logic [31:0] digits_o,
  output logic [7:0]  dp_o,
  output logic [31:0] frame_o,
  output logic        frame_valid_o,
  output logic        latch_valid_o,
  output logic        pat_err_o,
  output logic        sel_err_o,
  output logic        len_err_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IdleMax = IW'(TIMEOUT);

  logic [SYNC-1:0]  sh_sync_q, ds_sync_q, st_sync_q;
  logic             sh_d_q, st_d_q;
  logic [GUARD-1:0] guard_q;
  u16               sr_q, prev_q, word_q;
  logic [4:0]       bitcnt_q;
  logic             first_q, pend_q, len_bad_q;
  logic [IW-1:0]    idle_q;
  logic [7:0]       mask_q, dp_q;
  logic [31:0]      digits_q, frame_q;
  logic [15:0]      frame_cnt_q;
  logic             frame_valid_q, latch_valid_q, pat_err_q, sel_err_q, len_err_q;

  logic       sh_rise, st_rise, ds_s, guard_hit;
  u16         word_d;
  logic [4:0] shifts;
  logic       pat_hit;
  u4          pat_nib;
  logic [3:0] sel_cnt;
  logic [2:0] sel_idx;
  logic [31:0] digits_d;
  logic [7:0]  mask_d;

  assign sh_rise   = sh_sync_q[SYNC-1] & ~sh_d_q;
  assign st_rise   = st_sync_q[SYNC-1] & ~st_d_q;
  assign ds_s      = ds_sync_q[SYNC-1];
  assign guard_hit = |guard_q;

  // A shift in the same cycle has not landed yet, so sr_q is the finished word.
  // A shift that landed shortly before belongs to the next word, so prev_q is used.
  assign word_d = (guard_hit && !sh_rise) ? prev_q : sr_q;
  assign shifts = (guard_hit && !sh_rise) ? bitcnt_q - 5'd1 : bitcnt_q;

  seg_pat_decode u_pat_decode (
    .pat_i    (word_q[7:1]),
    .hit_o    (pat_hit),
    .nibble_o (pat_nib)
  );

  always_comb begin
    sel_cnt = '0;
    sel_idx = '0;
    for (int b = 0; b < 8; b++) begin
      if (word_q[8+b]) begin
        sel_cnt = sel_cnt + 4'd1;
        sel_idx = 3'(7 - b);
      end
    end
    digits_d = digits_q;
    digits_d[{sel_idx, 2'b00} +: 4] = pat_nib;
    mask_d = mask_q | (8'd1 << sel_idx);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_sync_q     <= '0;
      ds_sync_q     <= '0;
      st_sync_q     <= '0;
      sh_d_q        <= 1'b0;
      st_d_q        <= 1'b0;
      guard_q       <= '0;
      sr_q          <= '0;
      prev_q        <= '0;
      word_q        <= '0;
      bitcnt_q      <= '0;
      first_q       <= 1'b1;
      pend_q        <= 1'b0;
      len_bad_q     <= 1'b0;
      idle_q        <= '0;
      mask_q        <= '0;
      dp_q          <= '0;
      digits_q      <= '0;
      frame_q       <= '0;
      frame_cnt_q   <= '0;
      frame_valid_q <= 1'b0;
      latch_valid_q <= 1'b0;
      pat_err_q     <= 1'b0;
      sel_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
    end else begin
      sh_sync_q <= {sh_sync_q[SYNC-2:0], sh_clk_i};
      ds_sync_q <= {ds_sync_q[SYNC-2:0], ds_i};
      st_sync_q <= {st_sync_q[SYNC-2:0], st_clk_i};
      sh_d_q    <= sh_sync_q[SYNC-1];
      st_d_q    <= st_sync_q[SYNC-1];
      guard_q   <= GUARD'({guard_q, sh_rise});

      frame_valid_q <= 1'b0;
      latch_valid_q <= 1'b0;
      pat_err_q     <= 1'b0;
      sel_err_q     <= 1'b0;
      len_err_q     <= 1'b0;

      if (sh_rise) begin
        prev_q <= sr_q;
        sr_q   <= {ds_s, sr_q[15:1]};
        if (bitcnt_q != 5'd31) bitcnt_q <= bitcnt_q + 5'd1;
      end

      pend_q <= st_rise;
      if (st_rise) begin
        word_q    <= word_d;
        len_bad_q <= !first_q && (shifts != 5'(WORD_BITS));
        first_q   <= 1'b0;
        // A coinciding shift is the first bit of the next word.
        bitcnt_q  <= (sh_rise || guard_hit) ? 5'd1 : 5'd0;
        idle_q    <= '0;
      end else if (idle_q != IdleMax) begin
        idle_q <= idle_q + IW'(1);
      end

      if (idle_q == IdleMax) mask_q <= '0;

      if (pend_q) begin
        len_err_q <= len_bad_q;
        pat_err_q <= !pat_hit;
        sel_err_q <= (sel_cnt != 4'd1);
        if (pat_hit && sel_cnt == 4'd1) begin
          latch_valid_q      <= 1'b1;
          digits_q           <= digits_d;
          dp_q[sel_idx]      <= ~word_q[0];
          mask_q             <= mask_d;
          if (sel_idx == 3'd7) begin
            mask_q <= '0;
            if (mask_d == 8'hFF) begin
              frame_q       <= digits_d;
              frame_valid_q <= 1'b1;
              frame_cnt_q   <= frame_cnt_q + 16'd1;
            end
          end
        end
      end
    end
  end

  assign digits_o      = digits_q;
  assign dp_o          = dp_q;
  assign frame_o       = frame_q;
  assign frame_valid_o = frame_valid_q;
  assign latch_valid_o = latch_valid_q;
  assign pat_err_o     = pat_err_q;
  assign sel_err_o     = sel_err_q;
  assign len_err_o     = len_err_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule
